// File: rtl/sbox_new_area_pipe.sv
// Two-stage streaming AES S-box / inverse S-box over GF((2^4)^2).
// Stage 1 registers the out_mult operands; stage 2 multiplies and maps back.

module out_mult (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] e,
    input  logic [1:0] ap,
    input  logic [1:0] bp,
    output logic [3:0] z,
    output logic [3:0] w
);

    function automatic logic [2:0] clmul2(input logic [1:0] x, input logic [1:0] y);
        return {x[1] & y[1], (x[1] & y[0]) ^ (x[0] & y[1]), x[0] & y[0]};
    endfunction

    // Karatsuba over 2-bit halves, then reduce mod x^4 + x + 1
    function automatic logic [3:0] kmul(input logic [3:0] x, input logic [1:0] xp,
                                        input logic [3:0] y, input logic [1:0] yp);
        logic [2:0] hi;
        logic [2:0] lo;
        logic [2:0] mid;
        logic [6:0] p;
        hi  = clmul2(x[3:2], y[3:2]);
        lo  = clmul2(x[1:0], y[1:0]);
        mid = clmul2(xp, yp) ^ hi ^ lo;
        p   = {hi, 4'h0} ^ {2'b00, mid, 2'b00} ^ {4'h0, lo};
        return p[3:0] ^ (p[4] ? 4'h3 : 4'h0) ^ (p[5] ? 4'h6 : 4'h0) ^ (p[6] ? 4'hC : 4'h0);
    endfunction

    logic [1:0] ep;

    always_comb begin
        ep = e[3:2] ^ e[1:0];
        z  = kmul(a, ap, e, ep);
        w  = kmul(a ^ b, ap ^ bp, e, ep);
    end

endmodule

module sbox_new_area_pipe #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       count
);

    localparam logic [3:0] LAMBDA = 4'hC;

    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] t;
        r = 4'h0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ t;
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
        end
        return r;
    endfunction

    function automatic logic [3:0] gf16_inv(input logic [3:0] x);
        logic [3:0] x2;
        logic [3:0] x4;
        logic [3:0] x8;
        x2 = gf16_mul(x, x);
        x4 = gf16_mul(x2, x2);
        x8 = gf16_mul(x4, x4);
        return gf16_mul(gf16_mul(x8, x4), x2);
    endfunction

    // Composite element {h,l} = h*y + l with y^2 = y + LAMBDA
    function automatic logic [7:0] cmul(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh;
        hh = gf16_mul(a[7:4], b[7:4]);
        return {hh ^ gf16_mul(a[7:4], b[3:0]) ^ gf16_mul(a[3:0], b[7:4]),
                gf16_mul(hh, LAMBDA) ^ gf16_mul(a[3:0], b[3:0])};
    endfunction

    function automatic logic [7:0] lin(input logic [63:0] m, input logic [7:0] v);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = r ^ m[8*i +: 8];
        end
        return r;
    endfunction

    // Basis columns are powers of a root of the AES polynomial
    function automatic logic [63:0] calc_map();
        logic [7:0]  c;
        logic [7:0]  c2;
        logic [7:0]  c4;
        logic [7:0]  beta;
        logic [7:0]  pw;
        logic [63:0] m;
        beta = 8'h00;
        for (int k = 2; k < 256; k++) begin
            c  = 8'(k);
            c2 = cmul(c, c);
            c4 = cmul(c2, c2);
            if ((cmul(c4, c4) ^ c4 ^ cmul(c2, c) ^ c ^ 8'h01) == 8'h00) beta = c;
        end
        m  = '0;
        pw = 8'h01;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = pw;
            pw = cmul(pw, beta);
        end
        return m;
    endfunction

    function automatic logic [63:0] calc_imap(input logic [63:0] m);
        logic [63:0] r;
        logic [7:0]  tgt;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            tgt = 8'h01 << j;
            for (int x = 0; x < 256; x++) begin
                if (lin(m, 8'(x)) == tgt) r[8*j +: 8] = 8'(x);
            end
        end
        return r;
    endfunction

    localparam logic [63:0] MAP  = calc_map();
    localparam logic [63:0] IMAP = calc_imap(MAP);

    logic             s1_valid;
    logic [3:0]       s1_a;
    logic [3:0]       s1_b;
    logic [3:0]       s1_e;
    logic [1:0]       s1_ap;
    logic [1:0]       s1_bp;
    logic             s1_inv;
    logic [TAG_W-1:0] s1_tag;

    logic       s2_accept;
    logic       s1_advance;
    logic       in_fire;
    logic [7:0] x_std;
    logic [7:0] x_cmp;
    logic [3:0] a_n;
    logic [3:0] b_n;
    logic [3:0] d_n;
    logic [3:0] e_n;
    logic [3:0] z;
    logic [3:0] w;
    logic [7:0] v_std;
    logic [7:0] res;

    always_comb begin
        s2_accept  = !out_valid || out_ready;
        s1_advance = s1_valid && s2_accept;
        in_ready   = !s1_valid || s2_accept;
        in_fire    = in_valid && in_ready;
        count      = {1'b0, s1_valid} + {1'b0, out_valid};
    end

    // Inverse direction: undo the affine step (constant folded in) first
    always_comb begin
        x_std = in_data;
        if (in_inv) begin
            x_std = in_data ^ 8'h63;
            x_std = {x_std[6:0], x_std[7]} ^ {x_std[4:0], x_std[7:5]}
                  ^ {x_std[1:0], x_std[7:2]};
        end
        x_cmp = lin(MAP, x_std);
        a_n   = x_cmp[7:4];
        b_n   = x_cmp[3:0];
        d_n   = gf16_mul(LAMBDA, gf16_mul(a_n, a_n))
              ^ gf16_mul(a_n, b_n) ^ gf16_mul(b_n, b_n);
        e_n   = gf16_inv(d_n);
    end

    out_mult u_out_mult (
        .a  (s1_a),
        .b  (s1_b),
        .e  (s1_e),
        .ap (s1_ap),
        .bp (s1_bp),
        .z  (z),
        .w  (w)
    );

    always_comb begin
        v_std = lin(IMAP, {z, w});
        res   = v_std;
        if (!s1_inv) begin
            res = v_std ^ {v_std[6:0], v_std[7]} ^ {v_std[5:0], v_std[7:6]}
                ^ {v_std[4:0], v_std[7:5]} ^ {v_std[3:0], v_std[7:4]} ^ 8'h63;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_e      <= '0;
            s1_ap     <= '0;
            s1_bp     <= '0;
            s1_inv    <= 1'b0;
            s1_tag    <= '0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_tag   <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_a     <= a_n;
                s1_b     <= b_n;
                s1_e     <= e_n;
                s1_ap    <= a_n[3:2] ^ a_n[1:0];
                s1_bp    <= b_n[3:2] ^ b_n[1:0];
                s1_inv   <= in_inv;
                s1_tag   <= in_tag;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
            if (s1_advance) begin
                out_valid <= 1'b1;
                out_data  <= res;
                out_tag   <= s1_tag;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/sbox_new_area_pipe.md
# sbox_new_area_pipe

Two-stage pipelined wrapper around the new-area combined AES S-box / inverse S-box datapath, with valid/ready handshakes on both sides. The pipeline cut sits directly upstream of `out_mult`:
- **Stage 1** computes and registers the multiplier operands (A, B, E, Ap, Bp).
- **Stage 2** runs `out_mult` and the output basis map into a registered output byte.

The block is the streaming S-box slice used by the iterative AES core: one byte per cycle, two-cycle latency, per-byte direction select.

## Interface
Parameters:
- `TAG_W`, default 4: width of the sideband tag carried alongside each byte.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  input byte present.
- `in_ready`  out  1  block accepts input this cycle.
- `in_data`  in  8  byte to substitute.
- `in_inv`  in  1  0 = forward S-box, 1 = inverse S-box.
- `in_tag`  in  TAG_W  sideband, returned unchanged with the result.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result this cycle.
- `out_data`  out  8  SBOX(in_data) or INV_SBOX(in_data).
- `out_tag`  out  TAG_W  tag of the item on `out_data`.
- `count`  out  2  items in flight (0..2).

## Operation
**Stage 1 register (s1):** holds `s1_valid`, A[3:0], B[3:0], E[3:0], Ap, Bp, inv, tag. Its combinational input logic is:
- Input basis change, direction dependent. The inverse path includes the inverse affine transform with constant 0x63 removed.
- GF(2^4) square-scale, multiply and inversion producing E.
- Operand formation: A, B are the two 4-bit halves; Ap, Bp are their parity terms.

**Stage 2 register (s2):** holds `out_valid`, `out_data`, `out_tag`. Its input logic is:
- Instantiated `out_mult`, producing Z[3:0] and W[3:0].
- Output basis change to the standard basis, direction selected by the registered s1 inv. The forward path includes the affine transform and XOR 0x63.

**Handshake:**
- `s2_accept = !out_valid | out_ready`.
- `s1_advance = s1_valid & s2_accept`.
- `in_ready = !s1_valid | s2_accept`. This is combinational from `out_ready`, which is acceptable: there is no path from `in_valid` to `in_ready`.
- A transfer occurs when valid & ready are high in the same cycle. Upstream holds `in_data`, `in_inv`, `in_tag` stable while `in_valid & !in_ready`.

**Register updates:**
- s1 loads on input transfer.
- `s1_valid` clears when s1 advances with no new input.
- s2 loads on `s1_advance`. `out_valid` clears on output transfer with no `s1_advance`.
- Data registers load only on their transfer; they hold otherwise, including while bubbles pass.

**Other rules:**
- `count = s1_valid + out_valid`.
- Ordering is strictly FIFO. There is no drop and no duplication.
- `in_inv` is per item: mixed-direction streams are legal back-to-back.

## Timing
- **Reset (reset_n = 0 at a clock edge):** `s1_valid` = 0, `out_valid` = 0, `out_data` = 0x00, `out_tag` = 0, all s1 operand registers = 0, `count` = 0. `in_ready` reads 1 the cycle after reset.
- **Reset mid-operation:** all in-flight items are discarded. No stale item appears after reset is released.
- **Latency:** an item accepted at edge N appears on `out_data` / `out_valid` after edge N+1, provided `out_ready` was not blocking.
- **Throughput:** 1 item per cycle with `out_ready` held high.
- **Full pipe (count = 2) with `out_ready` = 0:** `in_ready` = 0 and all registers hold. `out_data` / `out_tag` stay stable while `out_valid & !out_ready`.
- **Full pipe, `out_ready` = 1, `in_valid` = 1:** output retires, s1 moves to s2 and the new item enters s1 in the same edge. `count` stays 2.
- **Empty s1, `out_valid` & `!out_ready`:** one new item is accepted into s1 (`count` becomes 2), then the pipe stalls.

## Test plan
- **Reset:** hold `reset_n` = 0 for 2 cycles -> `out_valid` = 0, `count` = 0, `out_data` = 0x00, and `in_ready` = 1 after release.
- **Single forward byte:** `in_data` = 0x00, inv = 0, tag = 3 -> exactly 2 cycles later `out_data` = 0x63, `out_tag` = 3, for one cycle with `out_ready` = 1.
- **Back-to-back forward stream:** 0x53, 0x01, 0xFF with `out_ready` = 1 -> 0xED, 0x7C, 0x16 on consecutive cycles; `in_ready` stays 1.
- **Interleaved inverse/forward:** inverse 0x63, forward 0x00, inverse 0xED, inverse 0x7C -> 0x00, 0x63, 0x53, 0x01 in order. Follow with an exhaustive sweep of all 256 bytes in both directions against the AES tables.
- **Backpressure:** `out_ready` = 0 while offering 4 items -> exactly 2 accepted, `in_ready` = 0, `count` = 2, `out_data` stable. Release `out_ready` -> all 4 emerge in order with matching tags, none lost or repeated.
- **Reset mid-stream:** assert `reset_n` = 0 with `count` = 2 -> next cycle `out_valid` = 0, `count` = 0. Neither discarded item appears after reset is released.
